instr_fetch_ctrl: RTL and testbench

- Sequences the 40-bit (5-byte) instruction register.
- Issues aligned 4-byte fetch requests to instruction memory and assembles the returned words in an 8-byte byte queue.
- Writes one complete 5-byte instruction into the instruction register whenever the queue holds at least 5 bytes and decode can accept one.
- Handles PC redirects (branches) by flushing the queue and discarding any in-flight fetch.

---
 rtl/instr_fetch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Instruction fetch sequencer for a 40-bit (5-byte) instruction
//               register. It issues aligned 4-byte fetch requests, collects
//               the returned words in an 8-byte byte queue, and writes one
//               complete instruction into the instruction register whenever
//               the queue holds at least five bytes and decode can accept it.
//               A PC redirect flushes the queue and discards any fetch that
//               is still in flight.
// Ports       :
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   redirect_valid/addr - one-cycle restart of fetch at a new byte address
//   fetch_req_*         - aligned word request handshake (valid/ready/addr)
//   fetch_rsp_valid/data- in-order word response, [31:24] = lowest address
//   ir_ready            - instruction register may be overwritten
//   ir_we/ir_wdata      - instruction register write, [39:32] = first byte
//   instr_pc            - PC of the instruction on ir_wdata
//   buf_count           - bytes currently held in the queue (0..8)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BUF_BYTES   = 8,
    parameter int          INSTR_BYTES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        fetch_req_valid,
    output logic [31:0] fetch_req_addr,
    input  logic        fetch_req_ready,
    input  logic        fetch_rsp_valid,
    input  logic [31:0] fetch_rsp_data,
    input  logic        ir_ready,
    output logic        ir_we,
    output logic [39:0] ir_wdata,
    output logic [31:0] instr_pc,
    output logic [3:0]  buf_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0]  c_ST_REQ   = 2'd0;
    localparam logic [1:0]  c_ST_WAIT  = 2'd1;
    localparam logic [1:0]  c_ST_DROP  = 2'd2;

    localparam int          c_BUF_W    = BUF_BYTES * 8;
    localparam int          c_IR_W     = INSTR_BYTES * 8;
    // A request is only made when a whole word still fits in the queue.
    localparam logic [3:0]  c_REQ_MAX  = 4'(BUF_BYTES - 4);
    localparam logic [3:0]  c_INSTR_LEN = 4'(INSTR_BYTES);
    localparam logic [31:0] c_PC_STEP  = 32'(INSTR_BYTES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [31:0]        r_fetch_addr;
    logic [1:0]         r_skip;
    logic [31:0]        r_head_pc;
    // Byte 0 (queue head) sits in the most significant byte. Bytes beyond
    // r_count are always kept at zero so new bytes can simply be OR-ed in.
    logic [c_BUF_W-1:0] r_buf;
    logic [3:0]         r_count;
    logic               r_ir_we;
    logic [39:0]        r_ir_wdata;
    logic [31:0]        r_instr_pc;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_issue;
    logic               w_append;
    logic [3:0]         w_rem;
    logic [2:0]         w_new_bytes;
    logic [c_BUF_W-1:0] w_shift;
    logic [31:0]        w_aligned;
    logic [c_BUF_W-1:0] w_ins;
    logic [c_BUF_W-1:0] w_next_buf;
    logic [3:0]         w_next_count;

    // The request is gated by rst so nothing is offered while reset is held.
    assign w_req_valid = !rst && (r_state == c_ST_REQ) && (r_count <= c_REQ_MAX);
    assign w_req_fire  = w_req_valid && fetch_req_ready;

    // Redirect wins over both issue and append.
    assign w_issue  = !redirect_valid && ir_ready && (r_count >= c_INSTR_LEN);
    assign w_append = !redirect_valid && (r_state == c_ST_WAIT) && fetch_rsp_valid;

    // Bytes left after an optional pop; appended bytes land right after them.
    assign w_rem       = w_issue ? (r_count - c_INSTR_LEN) : r_count;
    assign w_new_bytes = 3'd4 - {1'b0, r_skip};

    assign w_shift = w_issue ? {r_buf[c_BUF_W-c_IR_W-1:0], {c_IR_W{1'b0}}} : r_buf;

    // Drop the leading skip bytes of the word (post-redirect alignment),
    // then move the surviving bytes to byte position w_rem of the queue.
    assign w_aligned = fetch_rsp_data << {r_skip, 3'b000};
    assign w_ins     = {w_aligned, {(c_BUF_W-32){1'b0}}} >> {w_rem, 3'b000};

    assign w_next_buf   = w_append ? (w_shift | w_ins) : w_shift;
    assign w_next_count = w_append ? (w_rem + {1'b0, w_new_bytes}) : w_rem;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_REQ;
            r_fetch_addr <= RESET_PC & ~32'h3;
            r_skip       <= RESET_PC[1:0];
            r_head_pc    <= RESET_PC;
            r_buf        <= '0;
            r_count      <= 4'd0;
            r_ir_we      <= 1'b0;
            r_ir_wdata   <= 40'h0;
            r_instr_pc   <= 32'h0;
        end else begin
            // Fetch sequencing (one outstanding request at most).
            case (r_state)
                c_ST_REQ: begin
                    if (w_req_fire) begin
                        r_fetch_addr <= r_fetch_addr + 32'd4;
                        // A request accepted alongside a redirect is stale.
                        r_state      <= redirect_valid ? c_ST_DROP : c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (redirect_valid) begin
                        r_state <= fetch_rsp_valid ? c_ST_REQ : c_ST_DROP;
                    end else if (fetch_rsp_valid) begin
                        r_skip  <= 2'd0;
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_DROP: begin
                    if (fetch_rsp_valid) begin
                        r_state <= c_ST_REQ;
                    end
                end
                default: r_state <= c_ST_REQ;
            endcase

            // Instruction issue.
            r_ir_we <= w_issue;
            if (w_issue) begin
                r_ir_wdata <= r_buf[c_BUF_W-1 -: c_IR_W];
                r_instr_pc <= r_head_pc;
                r_head_pc  <= r_head_pc + c_PC_STEP;
            end

            r_buf   <= w_next_buf;
            r_count <= w_next_count;

            // Redirect: flush the queue and restart at the new PC. Later
            // assignments override the fetch-address update above.
            if (redirect_valid) begin
                r_buf        <= '0;
                r_count      <= 4'd0;
                r_head_pc    <= redirect_addr;
                r_fetch_addr <= redirect_addr & ~32'h3;
                r_skip       <= redirect_addr[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fetch_req_valid = w_req_valid;
    assign fetch_req_addr  = r_fetch_addr;
    assign ir_we           = r_ir_we;
    assign ir_wdata        = r_ir_wdata;
    assign instr_pc        = r_instr_pc;
    assign buf_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Directed self-checking bench for instr_fetch_ctrl. A small
//               in-bench memory answers each accepted request with the word
//               {a, a+1, a+2, a+3} (low address bytes) after a programmable
//               delay; expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        fetch_req_valid;
    logic [31:0] fetch_req_addr;
    logic        fetch_req_ready;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        ir_ready;
    logic        ir_we;
    logic [39:0] ir_wdata;
    logic [31:0] instr_pc;
    logic [3:0]  buf_count;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .BUF_BYTES   (8),
        .INSTR_BYTES (5)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_addr  (fetch_req_addr),
        .fetch_req_ready (fetch_req_ready),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_data  (fetch_rsp_data),
        .ir_ready        (ir_ready),
        .ir_we           (ir_we),
        .ir_wdata        (ir_wdata),
        .instr_pc        (instr_pc),
        .buf_count       (buf_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Memory model / observation state.
    logic [31:0] acc_q[$];
    logic [31:0] irpc_q[$];
    logic [39:0] irdat_q[$];
    int          overflow = 0;
    logic        last_acc;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          mem_delay;
    logic        inj;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    function automatic logic [31:0] acc_at(input int k);
        return (k < acc_q.size()) ? acc_q[k] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] irpc_at(input int k);
        return (k < irpc_q.size()) ? irpc_q[k] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [39:0] irdat_at(input int k);
        return (k < irdat_q.size()) ? irdat_q[k] : 40'hFF_FFFF_FFFF;
    endfunction

    // One clock cycle: sample the handshake before the edge, then, 1 ns
    // after the edge, drive the memory response and record DUT outputs.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = fetch_req_valid && fetch_req_ready;
        a   = fetch_req_addr;
        @(posedge clk);
        #1;
        last_acc = acc;
        if (acc) begin
            acc_q.push_back(a);
            pend      = 1'b1;
            pend_addr = a;
            pend_cnt  = mem_delay;
        end
        fetch_rsp_valid = 1'b0;
        fetch_rsp_data  = 32'h0;
        if (pend && pend_cnt == 0) begin
            fetch_rsp_valid = 1'b1;
            fetch_rsp_data  = mem_word(pend_addr);
            pend            = 1'b0;
        end else if (pend) begin
            pend_cnt--;
        end
        if (inj) begin
            fetch_rsp_valid = 1'b1;
            fetch_rsp_data  = 32'hDEAD_BEEF;
            inj             = 1'b0;
        end
        if (ir_we) begin
            irpc_q.push_back(instr_pc);
            irdat_q.push_back(ir_wdata);
        end
        if (buf_count > 4'd8) overflow++;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        irpc_q.delete();
        irdat_q.delete();
    endtask

    task automatic do_reset(input string tag);
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_addr   = 32'h0;
        fetch_req_ready = 1'b1;
        ir_ready        = 1'b0;
        inj             = 1'b0;
        pend            = 1'b0;
        mem_delay       = 0;
        cyc();
        cyc();
        check_eq({tag, "_rst_req_valid"}, 64'(fetch_req_valid), 64'd0);
        check_eq({tag, "_rst_count"},     64'(buf_count),       64'd0);
        check_eq({tag, "_rst_ir_we"},     64'(ir_we),           64'd0);
        check_eq({tag, "_rst_wdata"},     64'(ir_wdata),        64'd0);
        check_eq({tag, "_rst_pc"},        64'(instr_pc),        64'd0);
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        bit found;
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_addr   = 32'h0;
        fetch_req_ready = 1'b0;
        fetch_rsp_valid = 1'b0;
        fetch_rsp_data  = 32'h0;
        ir_ready        = 1'b0;
        inj             = 1'b0;
        pend            = 1'b0;
        pend_addr       = 32'h0;
        pend_cnt        = 0;
        mem_delay       = 0;
        last_acc        = 1'b0;

        // ---- 1: basic streaming from RESET_PC ----
        do_reset("t1");
        ir_ready = 1'b1;
        repeat (14) cyc();
        check_eq("t1_req0", 64'(acc_at(0)), 64'h0);
        check_eq("t1_req1", 64'(acc_at(1)), 64'h4);
        check_eq("t1_req2", 64'(acc_at(2)), 64'h8);
        check_eq("t1_i0_data", 64'(irdat_at(0)), 64'h00_0102_0304);
        check_eq("t1_i0_pc",   64'(irpc_at(0)),  64'h0);
        check_eq("t1_i1_data", 64'(irdat_at(1)), 64'h05_0607_0809);
        check_eq("t1_i1_pc",   64'(irpc_at(1)),  64'h5);
        check_eq("t1_i2_data", 64'(irdat_at(2)), 64'h0A_0B0C_0D0E);
        check_eq("t1_i2_pc",   64'(irpc_at(2)),  64'hA);

        // ---- 2: ir_ready low -> fetch stalls at a full queue ----
        do_reset("t2");
        repeat (10) cyc();
        check_eq("t2_nreq",  64'(acc_q.size()),  64'd2);
        check_eq("t2_req0",  64'(acc_at(0)),     64'h0);
        check_eq("t2_req1",  64'(acc_at(1)),     64'h4);
        check_eq("t2_no_ir", 64'(irpc_q.size()), 64'd0);
        check_eq("t2_full",  64'(buf_count),     64'd8);
        clear_logs();
        ir_ready = 1'b1;
        cyc();
        ir_ready = 1'b0;
        repeat (6) cyc();
        check_eq("t2_one_ir",  64'(irpc_q.size()), 64'd1);
        check_eq("t2_ir_data", 64'(irdat_at(0)),   64'h00_0102_0304);
        check_eq("t2_resume",  64'(acc_at(0)),     64'h8);
        check_eq("t2_count",   64'(buf_count),     64'd7);

        // ---- 3: redirect while waiting for the 0x10 response ----
        do_reset("t3");
        ir_ready        = 1'b1;
        fetch_req_ready = 1'b0;
        redirect_valid  = 1'b1;
        redirect_addr   = 32'h10;
        cyc();
        redirect_valid  = 1'b0;
        fetch_req_ready = 1'b1;
        mem_delay       = 2;
        cyc();
        check_eq("t3_req10", 64'(acc_at(0)), 64'h10);
        mem_delay      = 0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h102;
        cyc();
        redirect_valid = 1'b0;
        check_eq("t3_flush", 64'(buf_count), 64'd0);
        clear_logs();
        repeat (10) cyc();
        check_eq("t3_req100", 64'(acc_at(0)),   64'h100);
        check_eq("t3_req104", 64'(acc_at(1)),   64'h104);
        check_eq("t3_i0_pc",  64'(irpc_at(0)),  64'h102);
        check_eq("t3_i0_data",64'(irdat_at(0)), 64'h02_0304_0506);

        // ---- 4: redirect together with issue condition and a response ----
        do_reset("t4");
        repeat (8) cyc();
        check_eq("t4_full", 64'(buf_count), 64'd8);
        inj = 1'b1;
        cyc();
        clear_logs();
        ir_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        check_eq("t4_no_we", 64'(ir_we),     64'd0);
        check_eq("t4_count", 64'(buf_count), 64'd0);
        cyc();
        check_eq("t4_req_now", 64'(acc_q.size()),  64'd1);
        check_eq("t4_req200",  64'(acc_at(0)),     64'h200);
        check_eq("t4_no_ir",   64'(irpc_q.size()), 64'd0);

        // ---- 5: fetch_req_ready held low for 5 cycles ----
        do_reset("t5");
        fetch_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq($sformatf("t5_valid_%0d", i), 64'(fetch_req_valid), 64'd1);
            check_eq($sformatf("t5_addr_%0d", i),  64'(fetch_req_addr),  64'h0);
        end
        fetch_req_ready = 1'b1;
        cyc();
        check_eq("t5_one_acc", 64'(acc_q.size()),   64'd1);
        check_eq("t5_wait",    64'(fetch_req_valid), 64'd0);

        // ---- 6: reset while in WAIT, stale word after reset ----
        do_reset("t6");
        ir_ready  = 1'b1;
        mem_delay = 1;
        repeat (9) cyc();
        check_eq("t6_pre_data", 64'(ir_wdata), 64'h00_0102_0304);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (last_acc) found = 1'b1;
        end
        check_eq("t6_acc_seen", 64'(found), 64'd1);
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        mem_delay = 0;
        clear_logs();
        check_eq("t6_stale_pending", 64'(fetch_rsp_valid), 64'd1);
        cyc();
        check_eq("t6_count", 64'(buf_count), 64'd0);
        check_eq("t6_we",    64'(ir_we),     64'd0);
        check_eq("t6_wdata", 64'(ir_wdata),  64'd0);
        check_eq("t6_pc",    64'(instr_pc),  64'd0);
        check_eq("t6_req0",  64'(acc_at(0)), 64'h0);
        repeat (6) cyc();
        check_eq("t6_i0_data", 64'(irdat_at(0)), 64'h00_0102_0304);
        check_eq("t6_i0_pc",   64'(irpc_at(0)),  64'h0);

        check_eq("no_overflow", 64'(overflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
